branch_resolver: RTL and testbench

Sits directly downstream of the 2-bit predictor. Queues each issued prediction in order, matches it against the actual branch outcome when the branch resolves, and drives the predictor's update strobe (result) and direction (taken). Also flags mispredictions for pipeline flush and keeps saturating hit/miss statistics.

---
 rtl/branch_resolver_pkg.sv | 21 ++
 rtl/branch_pred_fifo.sv | 65 ++++++
 rtl/branch_resolver.sv | 84 ++++++++
 tb/tb_branch_resolver.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared branch-direction constants, predictor state encodings and
// the resolution bundle passed from resolver back to predictor.
package branch_resolver_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'd0,
    WEAK_NOT_TAKEN   = 2'd1,
    WEAK_TAKEN       = 2'd2,
    STRONG_TAKEN     = 2'd3
  } pred_state_e;

  typedef struct packed {
    logic result;
    logic taken;
    logic mispredict;
  } resolve_t;

endpackage

// File: rtl/branch_pred_fifo.sv
// In-order queue of 1-bit predictions; clear empties it and
// wins over a push in the same cycle.
module branch_pred_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        din_i,
  input  logic        pop_i,
  input  logic        clear_i,
  output logic        dout_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = din_i;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + AW'(1);
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push_i}
                    - {{AW{1'b0}}, pop_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Matches queued predictions against resolved outcomes, drives the
// predictor update strobe, flushes on mispredict, keeps statistics.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             prediction,
  output logic             pred_ready,
  input  logic             outcome_valid,
  input  logic             outcome_taken,
  output logic             result,
  output logic             taken,
  output logic             mispredict,
  output logic [AW:0]      occupancy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             underflow_err
);

  logic             head, full, empty;
  logic             push, pop, miss;
  resolve_t         res_q, res_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic             uf_q, uf_d;

  assign pop        = outcome_valid & ~empty;
  assign miss       = pop & (head != outcome_taken);
  assign pred_ready = ~full | pop;
  assign push       = pred_valid & pred_ready;

  // A mispredict makes every younger entry wrong-path.
  branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (prediction),
    .pop_i   (pop),
    .clear_i (miss),
    .dout_o  (head),
    .count_o (occupancy),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    res_d.result     = pop;
    res_d.taken      = pop ? outcome_taken : NOT_TAKEN;
    res_d.mispredict = miss;
    bc_d = bc_q;
    mc_d = mc_q;
    if (pop && bc_q != '1) bc_d = bc_q + CNT_W'(1);
    if (miss && mc_q != '1) mc_d = mc_q + CNT_W'(1);
    uf_d = uf_q | (outcome_valid & empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      bc_q  <= '0;
      mc_q  <= '0;
      uf_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      bc_q  <= bc_d;
      mc_q  <= mc_d;
      uf_q  <= uf_d;
    end
  end

  assign result        = res_q.result;
  assign taken         = res_q.taken;
  assign mispredict    = res_q.mispredict;
  assign branch_count  = bc_q;
  assign miss_count    = mc_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver (DEPTH=4, CNT_W=16 and a
// CNT_W=2 twin sharing the same stimulus for saturation).
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pred_valid = 1'b0;
  logic prediction = 1'b0;
  logic outcome_valid = 1'b0;
  logic outcome_taken = 1'b0;

  logic        pred_ready, result, taken, mispredict, underflow_err;
  logic [2:0]  occupancy;
  logic [15:0] branch_count, miss_count;

  logic        pred_ready2, result2, taken2, mispredict2, underflow_err2;
  logic [2:0]  occupancy2;
  logic [1:0]  branch_count2, miss_count2;

  branch_resolver #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .prediction(prediction),
    .pred_ready(pred_ready),
    .outcome_valid(outcome_valid), .outcome_taken(outcome_taken),
    .result(result), .taken(taken), .mispredict(mispredict),
    .occupancy(occupancy),
    .branch_count(branch_count), .miss_count(miss_count),
    .underflow_err(underflow_err)
  );

  branch_resolver #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .prediction(prediction),
    .pred_ready(pred_ready2),
    .outcome_valid(outcome_valid), .outcome_taken(outcome_taken),
    .result(result2), .taken(taken2), .mispredict(mispredict2),
    .occupancy(occupancy2),
    .branch_count(branch_count2), .miss_count(miss_count2),
    .underflow_err(underflow_err2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit       mq[$];
  resolve_t exp_q[$];
  int       bc, mc, bc2;
  bit       uf;
  bit       rdy_exp, rdy_dut;

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    bc = 0; mc = 0; bc2 = 0; uf = 0;
  endtask

  // Drive one cycle; the reference model predicts the next-cycle outputs.
  task automatic drive(input bit pv, input bit p,
                       input bit ov, input bit ot);
    bit pop, mis, h;
    resolve_t e;
    pred_valid = pv; prediction = p;
    outcome_valid = ov; outcome_taken = ot;
    #1;
    rdy_dut = pred_ready;
    rdy_exp = (mq.size() < 4) || (ov && mq.size() > 0);
    pop = ov && (mq.size() > 0);
    mis = 0;
    e = '0;
    if (pop) begin
      h = mq.pop_front();
      mis = (h != ot);
      e.result = 1'b1;
      e.taken = ot;
      e.mispredict = mis;
      if (bc < 65535) bc++;
      if (bc2 < 3) bc2++;
      if (mis) begin
        if (mc < 65535) mc++;
        mq.delete();
      end
    end else if (ov) begin
      uf = 1;
    end
    if (pv && rdy_exp && !mis) mq.push_back(p);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pred_valid = 0; prediction = 0;
    outcome_valid = 0; outcome_taken = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    pred_valid = 1; prediction = 1;
    outcome_valid = 1; outcome_taken = 1;
    @(posedge clk);
    #1;
    rst = 0;
    pred_valid = 0; prediction = 0;
    outcome_valid = 0; outcome_taken = 0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (occupancy !== 3'd0) begin
      bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy);
    end
    total++;
    if ({result, taken, mispredict} !== 3'b000) begin
      bad++; $display("FAIL rst_out got=%b exp=000",
                      {result, taken, mispredict});
    end
    total++;
    if (branch_count !== 16'd0 || miss_count !== 16'd0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
                      branch_count, miss_count);
    end
    total++;
    if (underflow_err !== 1'b0 || pred_ready !== 1'b1) begin
      bad++; $display("FAIL rst_flags got uf=%b rdy=%b exp uf=0 rdy=1",
                      underflow_err, pred_ready);
    end
  endtask

  task automatic test_push();
    resolve_t e;
    bit pat[3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, pat[i], 0, 0);
      e = exp_q.pop_front();
      total++;
      if ({result, taken, mispredict} !== e) begin
        bad++; $display("FAIL push_out%0d got=%b exp=%b", i,
                        {result, taken, mispredict}, e);
      end
    end
    total++;
    if (occupancy !== 3'(mq.size()) || pred_ready !== 1'b1) begin
      bad++; $display("FAIL push_occ got=%0d rdy=%b exp=%0d rdy=1",
                      occupancy, pred_ready, mq.size());
    end
  endtask

  task automatic test_match();
    resolve_t e;
    do_reset();
    drive(1, 1, 0, 0);
    void'(exp_q.pop_front());
    drive(0, 0, 1, 1);
    e = exp_q.pop_front();
    total++;
    if ({result, taken, mispredict} !== e) begin
      bad++; $display("FAIL match_out got=%b exp=%b",
                      {result, taken, mispredict}, e);
    end
    total++;
    if (branch_count !== 16'(bc) || miss_count !== 16'(mc)) begin
      bad++; $display("FAIL match_cnt got=%0d/%0d exp=%0d/%0d",
                      branch_count, miss_count, bc, mc);
    end
    drive(0, 0, 0, 0);
    e = exp_q.pop_front();
    total++;
    if ({result, taken, mispredict} !== e) begin
      bad++; $display("FAIL match_pulse got=%b exp=%b",
                      {result, taken, mispredict}, e);
    end
  endtask

  task automatic test_flush();
    resolve_t e;
    do_reset();
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 0);
    repeat (3) void'(exp_q.pop_front());
    drive(1, 1, 1, 0);
    e = exp_q.pop_front();
    total++;
    if ({result, taken, mispredict} !== e) begin
      bad++; $display("FAIL flush_out got=%b exp=%b",
                      {result, taken, mispredict}, e);
    end
    total++;
    if (occupancy !== 3'(mq.size()) || miss_count !== 16'(mc)) begin
      bad++; $display("FAIL flush_state got occ=%0d miss=%0d exp occ=%0d miss=%0d",
                      occupancy, miss_count, mq.size(), mc);
    end
    drive(0, 0, 1, 1);
    e = exp_q.pop_front();
    total++;
    if ({result, taken, mispredict} !== e || underflow_err !== 1'(uf)) begin
      bad++; $display("FAIL flush_drop got=%b uf=%b exp=%b uf=%b",
                      {result, taken, mispredict}, underflow_err, e, uf);
    end
  endtask

  task automatic test_full_wrap();
    resolve_t e;
    bit p, ot;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'(i), 0, 0);
      void'(exp_q.pop_front());
    end
    drive(1, 1, 0, 0);
    void'(exp_q.pop_front());
    total++;
    if (rdy_dut !== rdy_exp || occupancy !== 3'(mq.size())) begin
      bad++; $display("FAIL full_drop got rdy=%b occ=%0d exp rdy=%b occ=%0d",
                      rdy_dut, occupancy, rdy_exp, mq.size());
    end
    for (int i = 0; i < 8; i++) begin
      p = 1'($urandom_range(0, 1));
      ot = mq[0];
      drive(1, p, 1, ot);
      e = exp_q.pop_front();
      total++;
      if ({result, taken, mispredict} !== e || rdy_dut !== rdy_exp
          || occupancy !== 3'(mq.size())) begin
        bad++; $display("FAIL wrap%0d got=%b rdy=%b occ=%0d exp=%b rdy=%b occ=%0d",
                        i, {result, taken, mispredict}, rdy_dut, occupancy,
                        e, rdy_exp, mq.size());
      end
    end
    for (int i = 0; i < 4; i++) begin
      ot = mq[0];
      drive(0, 0, 1, ot);
      e = exp_q.pop_front();
      total++;
      if ({result, taken, mispredict} !== e) begin
        bad++; $display("FAIL drain%0d got=%b exp=%b", i,
                        {result, taken, mispredict}, e);
      end
    end
    total++;
    if (occupancy !== 3'd0 || branch_count !== 16'(bc)) begin
      bad++; $display("FAIL drain_end got occ=%0d bc=%0d exp occ=0 bc=%0d",
                      occupancy, branch_count, bc);
    end
  endtask

  task automatic test_underflow();
    resolve_t e;
    do_reset();
    drive(0, 0, 1, 1);
    e = exp_q.pop_front();
    total++;
    if ({result, taken, mispredict} !== e || underflow_err !== 1'(uf)
        || branch_count !== 16'(bc)) begin
      bad++; $display("FAIL uf_set got=%b uf=%b bc=%0d exp=%b uf=%b bc=%0d",
                      {result, taken, mispredict}, underflow_err, branch_count,
                      e, uf, bc);
    end
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    repeat (3) void'(exp_q.pop_front());
    total++;
    if (underflow_err !== 1'b1 || branch_count !== 16'(bc)) begin
      bad++; $display("FAIL uf_hold got uf=%b bc=%0d exp uf=1 bc=%0d",
                      underflow_err, branch_count, bc);
    end
    do_reset();
    total++;
    if (underflow_err !== 1'b0) begin
      bad++; $display("FAIL uf_clr got=%b exp=0", underflow_err);
    end
  endtask

  task automatic test_sat_and_rst();
    resolve_t e;
    do_reset();
    drive(1, 1, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1);
      e = exp_q.pop_front();
      total++;
      if ({result, taken, mispredict} !== e) begin
        bad++; $display("FAIL sat_out%0d got=%b exp=%b", i,
                        {result, taken, mispredict}, e);
      end
    end
    total++;
    if (branch_count2 !== 2'(bc2) || miss_count2 !== 2'd0
        || branch_count !== 16'(bc)) begin
      bad++; $display("FAIL sat_cnt got=%0d/%0d/%0d exp=%0d/0/%0d",
                      branch_count2, miss_count2, branch_count, bc2, bc);
    end
    drive(1, 0, 0, 0);
    void'(exp_q.pop_front());
    total++;
    if (occupancy !== 3'(mq.size())) begin
      bad++; $display("FAIL pre_rst_occ got=%0d exp=%0d",
                      occupancy, mq.size());
    end
    drive(0, 0, 1, 1);
    void'(exp_q.pop_front());
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    clear_model();
    total++;
    if ({result, taken, mispredict, underflow_err} !== 4'b0000
        || occupancy !== 3'd0 || branch_count !== 16'd0
        || miss_count !== 16'd0 || branch_count2 !== 2'd0) begin
      bad++; $display("FAIL mid_rst got out=%b occ=%0d bc=%0d mc=%0d bc2=%0d exp all 0",
                      {result, taken, mispredict, underflow_err}, occupancy,
                      branch_count, miss_count, branch_count2);
    end
  endtask

  initial begin
    test_reset();
    test_push();
    test_match();
    test_flush();
    test_full_wrap();
    test_underflow();
    test_sat_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
